// File: rtl/timebase_ctrl.sv
// Run/pause/adjust timebase: a CLK_HZ prescaler yields a one-cycle tick_1hz strobe.
// Define TIMEBASE_BLINK_EN to generate a 2 Hz blink in ADJUST; otherwise blink is tied high.
module timebase_ctrl #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned FAST_DIV = 10
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       adjust,
    input  logic       step,
    output logic       tick_1hz,
    output logic [1:0] state,
    output logic       blink
);

    localparam logic [31:0] WRAP_LAST = 32'(CLK_HZ - 1);
    localparam logic [31:0] HOLD_LAST = 32'(CLK_HZ / 2 - 1);
    localparam logic [31:0] FAST_LAST = 32'(CLK_HZ / FAST_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSE  = 2'b10,
        ADJUST = 2'b11
    } state_t;

    state_t      cur_state;
    state_t      next_state;
    logic [31:0] prescaler;
    logic [31:0] prescaler_next;
    logic        repeating;
    logic        repeating_next;
    logic        step_q;
    logic        tick_cand;
    logic        tick_next;

    assign state = cur_state;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            prescaler <= '0;
            repeating <= 1'b0;
            step_q    <= 1'b0;
            tick_1hz  <= 1'b0;
        end else begin
            cur_state <= next_state;
            prescaler <= prescaler_next;
            repeating <= repeating_next;
            step_q    <= step;
            tick_1hz  <= tick_next;
        end
    end

    // adjust overrides everything, and stop wins over start
    always_comb begin
        next_state = cur_state;
        if (adjust) begin
            next_state = ADJUST;
        end else begin
            case (cur_state)
                IDLE, PAUSE: if (start && !stop) next_state = RUN;
                RUN:         if (stop) next_state = PAUSE;
                ADJUST:      next_state = PAUSE;
            endcase
        end
    end

    // In ADJUST the prescaler measures how long step has been held since its rising edge;
    // repeating marks that the initial long hold has elapsed and fast repeat is active.
    always_comb begin
        prescaler_next = prescaler;
        repeating_next = repeating;
        tick_cand      = 1'b0;
        case (cur_state)
            RUN: begin
                tick_cand = (prescaler == WRAP_LAST);
                if (adjust) begin
                    prescaler_next = '0;
                end else if (stop) begin
                    prescaler_next = tick_cand ? '0 : prescaler;
                end else begin
                    prescaler_next = tick_cand ? '0 : prescaler + 32'd1;
                end
            end
            ADJUST: begin
                prescaler_next = '0;
                repeating_next = 1'b0;
                if (adjust && step) begin
                    if (!step_q) begin
                        tick_cand      = 1'b1;
                        prescaler_next = 32'd1;
                    end else if (prescaler != '0 || repeating) begin
                        repeating_next = repeating;
                        if (!repeating && prescaler == HOLD_LAST) begin
                            tick_cand      = 1'b1;
                            repeating_next = 1'b1;
                        end else if (repeating && prescaler == FAST_LAST) begin
                            tick_cand      = 1'b1;
                        end else begin
                            prescaler_next = prescaler + 32'd1;
                        end
                    end
                end
            end
            default: begin
                if (adjust) begin
                    prescaler_next = '0;
                    repeating_next = 1'b0;
                end
            end
        endcase
        // a RUN wrap followed at once by a step edge must not give back-to-back strobes
        tick_next = tick_cand && !tick_1hz;
    end

`ifdef TIMEBASE_BLINK_EN
    localparam logic [31:0] QUARTER_LAST = 32'(CLK_HZ / 4 - 1);

    logic [31:0] blink_cnt;

    // blink starts low on entry to ADJUST and toggles every quarter second while there
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (next_state == ADJUST) begin
            if (cur_state != ADJUST) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (blink_cnt == QUARTER_LAST) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end else begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end
    end
`else
    assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl at CLK_HZ=16, FAST_DIV=4: vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_timebase_ctrl;

    localparam int CLK_HZ   = 16;
    localparam int FAST_DIV = 4;
    localparam int HALF     = CLK_HZ / 2;
    localparam int FAST     = CLK_HZ / FAST_DIV;
    localparam int QUARTER  = CLK_HZ / 4;
`ifdef TIMEBASE_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       adjust;
    logic       step;
    logic       tick_1hz;
    logic [1:0] state;
    logic       blink;

    int errors;
    int checks;

    // reference model: state code, RUN phase, hold index since step rise, ADJUST cycle count
    int m_state;
    int m_p;
    int m_h;
    bit m_step_q;
    bit m_tick;
    int m_adj_n;
    bit m_blink;

    typedef struct {
        bit       rst;
        bit       go;
        bit       halt;
        bit       adj;
        bit       stp;
        bit [1:0] exp_state;
        bit       exp_tick;
        bit       exp_blink;
    } vec_t;

    vec_t vecs [15];

    timebase_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .FAST_DIV(FAST_DIV)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .adjust    (adjust),
        .step      (step),
        .tick_1hz  (tick_1hz),
        .state     (state),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input bit r, input bit s_go, input bit s_halt,
                                  input bit s_adj, input bit s_stp);
        reset  = r;
        start  = s_go;
        stop   = s_halt;
        adjust = s_adj;
        step   = s_stp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit hold_tick_due(input int h);
        if (h == 0) return 1'b1;
        if (h + 1 == HALF) return 1'b1;
        return (h + 1 > HALF) && ((h + 1 - HALF) % FAST == 0);
    endfunction

    task automatic model_update(input bit r, input bit s_go, input bit s_halt,
                                input bit s_adj, input bit s_stp);
        bit cand;
        int cur_h;
        int nstate;
        if (r) begin
            m_state = 0; m_p = 0; m_h = -1; m_step_q = 0;
            m_tick = 0; m_adj_n = 0; m_blink = 1;
            return;
        end
        cand  = 1'b0;
        cur_h = -1;
        if (m_state == 3 && s_adj && s_stp) begin
            if (!m_step_q) cur_h = 0;
            else if (m_h >= 0) cur_h = m_h + 1;
        end
        if (cur_h >= 0) cand = hold_tick_due(cur_h);
        if (m_state == 1 && m_p == CLK_HZ - 1) cand = 1'b1;
        if (s_adj || m_state == 3) m_p = 0;
        else if (m_state == 1 && !s_halt) m_p = (m_p + 1) % CLK_HZ;
        else if (m_state == 1 && m_p == CLK_HZ - 1) m_p = 0;
        m_h    = cur_h;
        m_tick = cand && !m_tick;
        if (s_adj) nstate = 3;
        else if (m_state == 3) nstate = 2;
        else if (m_state == 1) nstate = s_halt ? 2 : 1;
        else nstate = (s_go && !s_halt) ? 1 : m_state;
        if (nstate == 3) begin
            m_adj_n = (m_state == 3) ? m_adj_n + 1 : 0;
            m_blink = BLINK_EN ? (((m_adj_n / QUARTER) % 2) == 1) : 1'b1;
        end else begin
            m_adj_n = 0;
            m_blink = 1'b1;
        end
        m_state  = nstate;
        m_step_q = s_stp;
    endtask

    initial begin
        int tick_count;
        bit r_rst, r_go, r_halt, r_adj, r_stp;
        errors = 0;
        checks = 0;
        reset = 1'b1; start = 0; stop = 0; adjust = 0; step = 0;

        // rst go halt adj stp | state tick blink(with blink enabled)
        vecs[0]  = '{1, 0, 0, 0, 0, 2'd0, 0, 1};
        vecs[1]  = '{0, 0, 0, 0, 0, 2'd0, 0, 1};
        vecs[2]  = '{0, 1, 1, 0, 0, 2'd0, 0, 1};
        vecs[3]  = '{0, 1, 0, 0, 0, 2'd1, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 2'd1, 0, 1};
        vecs[5]  = '{0, 1, 1, 0, 0, 2'd2, 0, 1};
        vecs[6]  = '{0, 1, 0, 0, 0, 2'd1, 0, 1};
        vecs[7]  = '{0, 1, 1, 1, 0, 2'd3, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 1, 2'd3, 1, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 2'd3, 0, 0};
        vecs[10] = '{0, 0, 0, 1, 1, 2'd3, 1, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 2'd2, 0, 1};
        vecs[12] = '{0, 1, 0, 0, 0, 2'd1, 0, 1};
        vecs[13] = '{0, 0, 1, 0, 0, 2'd2, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 0, 2'd2, 0, 1};

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].go, vecs[i].halt, vecs[i].adj, vecs[i].stp);
            check_output($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check_output($sformatf("vec%0d_tick", i), tick_1hz, vecs[i].exp_tick);
            check_output($sformatf("vec%0d_blink", i), blink, BLINK_EN ? vecs[i].exp_blink : 1'b1);
        end

        // first tick CLK_HZ cycles after the first RUN cycle, then every CLK_HZ
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("run_entry_state", state, 1);
        check_output("run_entry_tick", tick_1hz, 0);
        for (int k = 1; k <= 3 * CLK_HZ; k++) begin
            apply_stimulus(0, 0, 0, 0, 0);
            check_output($sformatf("run_tick_k%0d", k), tick_1hz, (k % CLK_HZ == 0) ? 1 : 0);
        end

        // pause at prescaler 5 keeps the count; next tick after 11 RUN cycles
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("pause_state", state, 2);
        tick_count = 0;
        for (int k = 0; k < 40; k++) begin
            apply_stimulus(0, 0, 0, 0, 0);
            tick_count += int'(tick_1hz);
        end
        check_output("pause_tick_count", tick_count, 0);
        check_output("pause_hold_state", state, 2);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("resume_state", state, 1);
        for (int j = 1; j <= 12; j++) begin
            apply_stimulus(0, 0, 0, 0, 0);
            check_output($sformatf("resume_tick_j%0d", j), tick_1hz, (j == 11) ? 1 : 0);
        end

        // step pulses in ADJUST: one tick per rising edge
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("adjust_state", state, 3);
        tick_count = 0;
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(0, 0, 0, 1, 1);
            check_output($sformatf("pulse%0d_tick", n), tick_1hz, 1);
            tick_count += int'(tick_1hz);
            for (int q = 0; q < 3; q++) begin
                apply_stimulus(0, 0, 0, 1, 0);
                check_output($sformatf("pulse%0d_low%0d", n, q), tick_1hz, 0);
                tick_count += int'(tick_1hz);
            end
        end
        check_output("pulse_tick_count", tick_count, 3);

        // step held 30 cycles: rise+1, rise+8, then every 4 cycles; silent after release
        for (int i = 1; i <= 30; i++) begin
            apply_stimulus(0, 0, 0, 1, 1);
            check_output($sformatf("hold_tick_i%0d", i), tick_1hz,
                         (i == 1 || (i >= 8 && (i - 8) % 4 == 0)) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 0, 1, 0);
            check_output($sformatf("release_tick_%0d", i), tick_1hz, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("adjust_exit_state", state, 2);

        // asynchronous reset mid-RUN at prescaler 9
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) apply_stimulus(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_state", state, 0);
        check_output("async_reset_tick", tick_1hz, 0);
        check_output("async_reset_blink", blink, 1);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 0, 0, 0);
        check_output("post_reset_idle", state, 0);

        // blink pattern across an ADJUST stay
        for (int n = 0; n < 12; n++) begin
            apply_stimulus(0, 0, 0, 1, 0);
            check_output($sformatf("blink_n%0d", n), blink,
                         BLINK_EN ? (((n / QUARTER) % 2 == 1) ? 1 : 0) : 1);
        end
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("blink_after_adjust", blink, 1);

        // randomized traffic against the reference model
        apply_stimulus(1, 0, 0, 0, 0);
        model_update(1, 0, 0, 0, 0);
        r_adj = 0;
        r_stp = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rst  = ($urandom_range(0, 299) == 0);
            r_go   = ($urandom_range(0, 7) == 0);
            r_halt = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) r_adj = ~r_adj;
            if ($urandom_range(0, 9) == 0) r_stp = ~r_stp;
            apply_stimulus(r_rst, r_go, r_halt, r_adj, r_stp);
            model_update(r_rst, r_go, r_halt, r_adj, r_stp);
            check_output($sformatf("rand%0d_state", c), state, m_state);
            check_output($sformatf("rand%0d_tick", c), tick_1hz, m_tick);
            check_output($sformatf("rand%0d_blink", c), blink, m_blink);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 Parameter CLK_HZ, 100_000_000, input clock frequency in Hz; legal range 8..2^32-1.
REQ-002 Parameter FAST_DIV, 10, auto-repeat tick rate in Hz while step is held in ADJUST; legal range 1..CLK_HZ/4.
REQ-003 Port clk_100MHz  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  synchronous request to run the timebase; level sampled each cycle.
REQ-006 Port stop  input  1  synchronous request to pause the timebase; level sampled each cycle.
REQ-007 Port adjust  input  1  level; high selects time-setting mode.
REQ-008 Port step  input  1  level; in ADJUST, each rising edge requests one tick and holding it requests auto-repeat.
REQ-009 Port tick_1hz  output  1  registered one-cycle strobe that advances downstream time/calendar counters.
REQ-010 Port state  output  2  current FSM state: IDLE=00, RUN=01, PAUSE=10, ADJUST=11.
REQ-011 Port blink  output  1  display blink enable; see Configuration.

Function
REQ-012 FSM transitions SHALL be evaluated every cycle with priority adjust > stop > start.
REQ-013 From any state, adjust=1 SHALL move to ADJUST on the next edge and clear the 32-bit prescaler to 0.
REQ-014 In ADJUST, adjust=0 SHALL move to PAUSE with the prescaler at 0.
REQ-015 From IDLE or PAUSE, start=1 (with adjust=0, stop=0) SHALL move to RUN; the prescaler value SHALL be retained across PAUSE->RUN.
REQ-016 From RUN, stop=1 (with adjust=0) SHALL move to PAUSE and freeze the prescaler.
REQ-017 start and stop both high SHALL be resolved as stop (RUN->PAUSE; IDLE/PAUSE unchanged).
REQ-018 In RUN, the prescaler SHALL increment by 1 per cycle and wrap from CLK_HZ-1 to 0; tick_1hz SHALL be 1 in exactly the cycle after that wrap edge.
REQ-019 The first tick after IDLE->RUN SHALL assert CLK_HZ cycles after the first RUN cycle; the tick period in steady RUN SHALL be exactly CLK_HZ cycles.
REQ-020 A wrap coinciding with stop or adjust SHALL still produce its tick; no tick SHALL be generated in IDLE or PAUSE.
REQ-021 In ADJUST, a rising edge of step (registered step_q=0, step=1) SHALL assert tick_1hz on the next cycle for one cycle.
REQ-022 In ADJUST with step held, the prescaler SHALL count from the rising edge; after CLK_HZ/2 cycles held, one tick SHALL issue, then one every CLK_HZ/FAST_DIV cycles until step falls.
REQ-023 Releasing step, or leaving ADJUST, SHALL clear the prescaler and cancel any pending auto-repeat.
REQ-024 tick_1hz SHALL never be high for two consecutive cycles.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, prescaler=0, step_q=0, tick_1hz=0, blink=1.
REQ-026 Reset asserted mid-RUN or mid-ADJUST SHALL discard the partial count; after release, the block SHALL remain in IDLE until start.

Configuration
REQ-027 Macro TIMEBASE_BLINK_EN SHALL control blink generation.
REQ-028 With TIMEBASE_BLINK_EN defined, in ADJUST blink SHALL toggle every CLK_HZ/4 cycles (2 Hz square wave), starting low on ADJUST entry; in all other states it SHALL be 1.
REQ-029 Without TIMEBASE_BLINK_EN, blink SHALL be constant 1, no blink counter SHALL be synthesised, and the port SHALL remain present.

Verification (CLK_HZ=16, FAST_DIV=4)
REQ-030 reset, then start pulse 1 cycle -> state=01; tick_1hz single-cycle pulses 16 cycles after the first RUN cycle, then every 16 cycles.
REQ-031 RUN with prescaler=5, stop 1 cycle, wait 40 cycles, start -> no ticks during PAUSE; next tick after 11 RUN cycles.
REQ-032 start=stop=1 in RUN -> PAUSE; adjust=start=stop=1 -> ADJUST with prescaler cleared.
REQ-033 ADJUST, step pulsed 3 times (1 cycle high, 3 low) -> exactly 3 ticks, each the cycle after the step rise.
REQ-034 ADJUST, step held 30 cycles -> ticks at rise+1, rise+8, rise+12, rise+16 ... (ticks every 4 cycles after the first 8-cycle hold); none after step falls.
REQ-035 reset asserted mid-RUN at prescaler=9 -> immediate IDLE, tick_1hz=0; with the macro defined, blink toggles every 4 cycles in ADJUST and is 1 otherwise.
